// File: rtl/cpu_pkg.sv
// Shared CPU constants: register-file address width, counter width and ID/EX layout.
package cpu_pkg;

    localparam int ADDR_RFILE = 5;
    localparam int CNT_W      = 16;

    // Control flags carried alongside the three register addresses in ID/EX.
    typedef struct packed {
        logic rfileW;
        logic memR;
        logic bubble;
        logic flush;
    } ex_flags_t;

    localparam int EX_FLAGS_W       = $bits(ex_flags_t);
    localparam int IDEX_ADDR_FIELDS = 3;

endpackage

// File: rtl/sat_cnt.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_pipe.sv
// Load-use hazard detection and branch flush for the ID/EX -> EX/MEM -> MEM/WB
// control pipeline, with saturating stall and flush event counters.
module hazard_pipe #(
    parameter int ADDR_RFILE = cpu_pkg::ADDR_RFILE,
    parameter int CNT_W      = cpu_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_RFILE-1:0] id_addr_rs,
    input  logic [ADDR_RFILE-1:0] id_addr_rt,
    input  logic [ADDR_RFILE-1:0] id_wb_addr,
    input  logic                  id_rfile_w,
    input  logic                  id_mem_r,
    input  logic                  br_taken,
    output logic [ADDR_RFILE-1:0] addr_rs_t,
    output logic [ADDR_RFILE-1:0] addr_rt_t,
    output logic [ADDR_RFILE-1:0] wb_addr_t,
    output logic                  rfile_w_t2,
    output logic [ADDR_RFILE-1:0] wb_addr_t2,
    output logic                  rfile_w_t3,
    output logic                  stall_ctrl,
    output logic                  stall_ctrl_t2,
    output logic                  flush_ctrl_t,
    output logic                  ifid_flush,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    import cpu_pkg::*;

    localparam int IDEX_W = IDEX_ADDR_FIELDS * ADDR_RFILE + EX_FLAGS_W;

    logic [IDEX_W-1:0]     idEx_q;
    logic [IDEX_W-1:0]     idEx_d;
    logic [ADDR_RFILE-1:0] exAddrRs;
    logic [ADDR_RFILE-1:0] exAddrRt;
    logic [ADDR_RFILE-1:0] exWbAddr;
    ex_flags_t             exFlags;
    ex_flags_t             exFlags_d;
    logic                  loadUse;
    logic                  stall;

    logic [ADDR_RFILE-1:0] memWbAddr_q;
    logic                  memRfileW_q;
    logic                  memBubble_q;
    logic                  memFlush_q;
    logic [ADDR_RFILE-1:0] wbWbAddr_q;
    logic                  wbRfileW_q;

    assign {exAddrRs, exAddrRt, exWbAddr, exFlags} = idEx_q;

    // A taken branch squashes the ID instruction anyway, so it overrides the stall.
    always_comb begin
        loadUse = exFlags.memR && (exWbAddr != '0) &&
                  ((exWbAddr == id_addr_rs) || (exWbAddr == id_addr_rt));
        stall   = loadUse && !br_taken;

        exFlags_d        = '0;
        exFlags_d.rfileW = id_rfile_w && !stall && !br_taken;
        exFlags_d.memR   = id_mem_r   && !stall && !br_taken;
        exFlags_d.bubble = stall;
        exFlags_d.flush  = br_taken;

        idEx_d = {id_addr_rs, id_addr_rt, id_wb_addr, exFlags_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idEx_q      <= '0;
            memWbAddr_q <= '0;
            memRfileW_q <= 1'b0;
            memBubble_q <= 1'b0;
            memFlush_q  <= 1'b0;
            wbWbAddr_q  <= '0;
            wbRfileW_q  <= 1'b0;
        end else begin
            idEx_q      <= idEx_d;
            memWbAddr_q <= exWbAddr;
            memRfileW_q <= exFlags.rfileW;
            memBubble_q <= exFlags.bubble;
            memFlush_q  <= exFlags.flush;
            wbWbAddr_q  <= memWbAddr_q;
            wbRfileW_q  <= memRfileW_q;
        end
    end

    sat_cnt #(.CNT_W(CNT_W)) u_stallCnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (stall),
        .count_o(stall_cnt)
    );

    sat_cnt #(.CNT_W(CNT_W)) u_flushCnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (br_taken),
        .count_o(flush_cnt)
    );

    assign stall_ctrl    = stall;
    assign ifid_flush    = br_taken;
    assign addr_rs_t     = exAddrRs;
    assign addr_rt_t     = exAddrRt;
    assign wb_addr_t     = memWbAddr_q;
    assign rfile_w_t2    = memRfileW_q;
    assign stall_ctrl_t2 = memBubble_q;
    assign flush_ctrl_t  = memFlush_q;
    assign wb_addr_t2    = wbWbAddr_q;
    assign rfile_w_t3    = wbRfileW_q;

endmodule

// File: tb/tb_hazard_pipe.sv
// Directed bench for hazard_pipe: a default-width instance plus a CNT_W=2 instance
// sharing the same stimulus, so saturation shows up on the narrow counter.
module tb_hazard_pipe;

    import cpu_pkg::*;

    localparam int AW = ADDR_RFILE;
    localparam int CW = CNT_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] idRs, idRt, idWb;
    logic          idW, idMemR, brTaken;

    logic [AW-1:0] addrRsT, addrRtT, wbAddrT, wbAddrT2;
    logic          rfileWT2, rfileWT3, stallCtrl, stallCtrlT2, flushCtrlT, ifidFlush;
    logic [CW-1:0] stallCnt, flushCnt;

    logic [AW-1:0] sAddrRsT, sAddrRtT, sWbAddrT, sWbAddrT2;
    logic          sRfileWT2, sRfileWT3, sStallCtrl, sStallCtrlT2, sFlushCtrlT, sIfidFlush;
    logic [1:0]    sStallCnt, sFlushCnt;

    int vecCount  = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    hazard_pipe dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_addr_rs   (idRs),
        .id_addr_rt   (idRt),
        .id_wb_addr   (idWb),
        .id_rfile_w   (idW),
        .id_mem_r     (idMemR),
        .br_taken     (brTaken),
        .addr_rs_t    (addrRsT),
        .addr_rt_t    (addrRtT),
        .wb_addr_t    (wbAddrT),
        .rfile_w_t2   (rfileWT2),
        .wb_addr_t2   (wbAddrT2),
        .rfile_w_t3   (rfileWT3),
        .stall_ctrl   (stallCtrl),
        .stall_ctrl_t2(stallCtrlT2),
        .flush_ctrl_t (flushCtrlT),
        .ifid_flush   (ifidFlush),
        .stall_cnt    (stallCnt),
        .flush_cnt    (flushCnt)
    );

    hazard_pipe #(.CNT_W(2)) dutSmall (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_addr_rs   (idRs),
        .id_addr_rt   (idRt),
        .id_wb_addr   (idWb),
        .id_rfile_w   (idW),
        .id_mem_r     (idMemR),
        .br_taken     (brTaken),
        .addr_rs_t    (sAddrRsT),
        .addr_rt_t    (sAddrRtT),
        .wb_addr_t    (sWbAddrT),
        .rfile_w_t2   (sRfileWT2),
        .wb_addr_t2   (sWbAddrT2),
        .rfile_w_t3   (sRfileWT3),
        .stall_ctrl   (sStallCtrl),
        .stall_ctrl_t2(sStallCtrlT2),
        .flush_ctrl_t (sFlushCtrlT),
        .ifid_flush   (sIfidFlush),
        .stall_cnt    (sStallCnt),
        .flush_cnt    (sFlushCnt)
    );

    task automatic applyStimulus(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                                 input logic [AW-1:0] wb, input logic w,
                                 input logic memR, input logic br);
        idRs    = rs;
        idRt    = rt;
        idWb    = wb;
        idW     = w;
        idMemR  = memR;
        brTaken = br;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        assert (obs === exp) else begin
            missCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string pfx);
        checkOutput({pfx, "_addr_rs_t"},     32'(addrRsT),      0);
        checkOutput({pfx, "_addr_rt_t"},     32'(addrRtT),      0);
        checkOutput({pfx, "_wb_addr_t"},     32'(wbAddrT),      0);
        checkOutput({pfx, "_rfile_w_t2"},    32'(rfileWT2),     0);
        checkOutput({pfx, "_wb_addr_t2"},    32'(wbAddrT2),     0);
        checkOutput({pfx, "_rfile_w_t3"},    32'(rfileWT3),     0);
        checkOutput({pfx, "_stall_ctrl"},    32'(stallCtrl),    0);
        checkOutput({pfx, "_stall_ctrl_t2"}, 32'(stallCtrlT2),  0);
        checkOutput({pfx, "_flush_ctrl_t"},  32'(flushCtrlT),   0);
        checkOutput({pfx, "_ifid_flush"},    32'(ifidFlush),    0);
        checkOutput({pfx, "_stall_cnt"},     32'(stallCnt),     0);
        checkOutput({pfx, "_flush_cnt"},     32'(flushCnt),     0);
        checkOutput({pfx, "_s_pipe"},
                    32'({sAddrRsT, sAddrRtT, sWbAddrT, sRfileWT2, sWbAddrT2, sRfileWT3}), 0);
        checkOutput({pfx, "_s_ctrl"},
                    32'({sStallCtrl, sStallCtrlT2, sFlushCtrlT, sIfidFlush, sStallCnt, sFlushCnt}), 0);
    endtask

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b0);
        #12;
        checkAllZero("reset");
        rst_n = 1'b1;

        $display("[TB] ALU write to r5 followed by nops");
        applyStimulus(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("alu_addr_rs_t",  32'(addrRsT),   1);
        checkOutput("alu_addr_rt_t",  32'(addrRtT),   2);
        checkOutput("alu_rfw_t2_e1",  32'(rfileWT2),  0);
        tick();
        checkOutput("alu_wb_addr_t",  32'(wbAddrT),   5);
        checkOutput("alu_rfile_w_t2", 32'(rfileWT2),  1);
        tick();
        checkOutput("alu_wb_addr_t2", 32'(wbAddrT2),  5);
        checkOutput("alu_rfile_w_t3", 32'(rfileWT3),  1);
        checkOutput("alu_rfw_t2_e3",  32'(rfileWT2),  0);

        $display("[TB] load to r0 then use of r0");
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(5'd0, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("r0_stall_ctrl",  32'(stallCtrl), 0);
        tick();
        checkOutput("r0_stall_cnt",   32'(stallCnt),  0);
        tick();
        checkOutput("r0_stall_t2",    32'(stallCtrlT2), 0);
        checkOutput("r0_wb_addr_t",   32'(wbAddrT),   4);
        checkOutput("r0_rfile_w_t2",  32'(rfileWT2),  1);

        $display("[TB] load r8 then use of r8");
        applyStimulus(5'd3, 5'd4, 5'd8, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("lu_no_early_stall", 32'(stallCtrl), 0);
        tick();
        applyStimulus(5'd8, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("lu_stall_ctrl",  32'(stallCtrl), 1);
        checkOutput("lu_ifid_flush",  32'(ifidFlush), 0);
        tick();
        checkOutput("lu_no_restall",  32'(stallCtrl), 0);
        checkOutput("lu_stall_cnt",   32'(stallCnt),  1);
        checkOutput("lu_t2_early",    32'(stallCtrlT2), 0);
        checkOutput("lu_load_wb",     32'(wbAddrT),   8);
        checkOutput("lu_load_rfw",    32'(rfileWT2),  1);
        tick();
        applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("lu_stall_t2",    32'(stallCtrlT2), 1);
        checkOutput("lu_bubble_rfw",  32'(rfileWT2),  0);
        tick();
        checkOutput("lu_t2_clear",    32'(stallCtrlT2), 0);
        checkOutput("lu_use_wb",      32'(wbAddrT),   10);
        checkOutput("lu_use_rfw",     32'(rfileWT2),  1);
        checkOutput("lu_stall_cnt2",  32'(stallCnt),  1);

        $display("[TB] taken branch coinciding with load-use");
        applyStimulus(5'd3, 5'd4, 5'd8, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(5'd8, 5'd9, 5'd10, 1'b1, 1'b0, 1'b1);
        #1;
        checkOutput("br_stall_ctrl",  32'(stallCtrl), 0);
        checkOutput("br_ifid_flush",  32'(ifidFlush), 1);
        tick();
        applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("br_ifid_low",    32'(ifidFlush), 0);
        checkOutput("br_flush_cnt",   32'(flushCnt),  1);
        checkOutput("br_stall_cnt",   32'(stallCnt),  1);
        checkOutput("br_flush_early", 32'(flushCtrlT), 0);
        tick();
        checkOutput("br_flush_ctrl_t", 32'(flushCtrlT), 1);
        checkOutput("br_no_bubble",   32'(stallCtrlT2), 0);
        checkOutput("br_flushed_rfw", 32'(rfileWT2),  0);
        checkOutput("br_flushed_wb",  32'(wbAddrT),   10);
        tick();
        checkOutput("br_flush_clear", 32'(flushCtrlT), 0);

        $display("[TB] five back-to-back load-use stalls");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(5'd1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0);
            tick();
            applyStimulus(5'd6, 5'd3, 5'd11, 1'b1, 1'b0, 1'b0);
            #1;
            checkOutput($sformatf("loop%0d_stall_ctrl", i), 32'(stallCtrl), 1);
            tick();
        end
        checkOutput("sat_wide_cnt",   32'(stallCnt),  6);
        checkOutput("sat_small_cnt",  32'(sStallCnt), 3);
        checkOutput("sat_small_flush", 32'(sFlushCnt), 1);

        $display("[TB] asynchronous reset during a stall");
        applyStimulus(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(5'd7, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("ar_stall_ctrl",  32'(stallCtrl), 1);
        checkOutput("ar_bubble_t2",   32'(stallCtrlT2), 1);
        checkOutput("ar_bubble_wb",   32'(wbAddrT),   11);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("async_rst");
        #2;
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_stall", 32'(stallCtrl), 0);
        checkOutput("post_rst_rs",    32'(addrRsT),   7);
        checkOutput("post_rst_cnt",   32'(stallCnt),  0);
        tick();
        checkOutput("post_rst_wb",    32'(wbAddrT),   11);
        checkOutput("post_rst_rfw",   32'(rfileWT2),  1);
        checkOutput("post_rst_t2",    32'(stallCtrlT2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
